// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Assembles six-byte command frames (HDR, OP, ADDR, DH, DL, CHK) arriving one
// byte per rx_done strobe from a UART receiver. It presents each checksum-valid
// command on a valid/ready interface and reports framing problems as a
// one-cycle error strobe with a sticky error code.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   rx_data    received byte, qualified by rx_done
//   rx_done    one-cycle strobe per received byte
//   cmd_valid  a decoded command is being offered
//   cmd_ready  consumer accepts the offered command
//   cmd_op     command opcode
//   cmd_addr   register address
//   cmd_wdata  write data {DH, DL}
//   frame_err  one-cycle error strobe
//   err_code   last error: 01 checksum, 10 timeout, 11 overrun
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [7:0]  HDR         = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  // Counter just wide enough to hold TIMEOUT_CYC itself.
  localparam int unsigned      CNT_W     = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_OVR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    OP,
    ADDR,
    DH,
    DL,
    CHK,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] idle_cnt;
  logic [7:0]       op_q;
  logic [7:0]       addr_q;
  logic [7:0]       dh_q;
  logic [7:0]       dl_q;
  logic             in_frame;
  logic             timed_out;
  logic             chk_match;
  logic             load_cmd;
  logic             err_fire;
  logic [1:0]       err_val;

  assign in_frame  = (state != IDLE) && (state != HOLD);
  assign timed_out = in_frame && (idle_cnt >= CNT_LIMIT);
  assign chk_match = ((op_q ^ addr_q ^ dh_q ^ dl_q) == rx_data);

  // The command is offered exactly while the FSM waits in HOLD, so the
  // valid flag cannot drift out of step with the state.
  assign cmd_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_cmd   = 1'b0;
    err_fire   = 1'b0;
    err_val    = ERR_CHK;
    case (state)
      IDLE: begin
        if (rx_done && (rx_data == HDR)) state_next = OP;
      end
      OP: begin
        if (rx_done) state_next = ADDR;
      end
      ADDR: begin
        if (rx_done) state_next = DH;
      end
      DH: begin
        if (rx_done) state_next = DL;
      end
      DL: begin
        if (rx_done) state_next = CHK;
      end
      CHK: begin
        if (rx_done) begin
          if (chk_match) begin
            state_next = HOLD;
            load_cmd   = 1'b1;
          end else begin
            state_next = IDLE;
            err_fire   = 1'b1;
            err_val    = ERR_CHK;
          end
        end
      end
      HOLD: begin
        // A byte arriving here is lost; the handshake still completes in
        // the same cycle if the consumer happens to accept.
        if (rx_done) begin
          err_fire = 1'b1;
          err_val  = ERR_OVR;
        end
        if (cmd_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A byte arriving on the timeout cycle takes priority over the timeout.
    if (timed_out && !rx_done) begin
      state_next = IDLE;
      err_fire   = 1'b1;
      err_val    = ERR_TMO;
    end
  end

  // Idle counter: held at zero outside a frame and on every byte, then
  // counts quiet cycles and sticks at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!in_frame || rx_done) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_LIMIT) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Frame field capture; every frame rewrites all four fields before CHK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      addr_q <= '0;
      dh_q   <= '0;
      dl_q   <= '0;
    end else if (rx_done) begin
      case (state)
        OP:      op_q   <= rx_data;
        ADDR:    addr_q <= rx_data;
        DH:      dh_q   <= rx_data;
        DL:      dl_q   <= rx_data;
        default: ;
      endcase
    end
  end

  // Registered outputs: command fields only change when a new command is
  // accepted, and err_code keeps the last error until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_op    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      frame_err <= err_fire;
      if (err_fire) err_code <= err_val;
      if (load_cmd) begin
        cmd_op    <= op_q;
        cmd_addr  <= addr_q;
        cmd_wdata <= {dh_q, dl_q};
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Directed scenarios plus a randomized byte stream, checked against a
// byte-level reference model of the framing rules.
module tb_uart_cmd_parser;

  localparam int unsigned T   = 50;
  localparam logic [7:0]  HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        frame_err;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: m_pos counts frame bytes collected after HDR
  // (0 = hunting for HDR), m_quiet counts strobe-free cycles inside a frame.
  int          m_pos;
  int          m_quiet;
  bit          m_pend;
  logic [7:0]  m_buf [0:5];
  logic [7:0]  e_op;
  logic [7:0]  e_addr;
  logic [15:0] e_wdata;
  logic        e_ferr;
  logic [1:0]  e_code;

  uart_cmd_parser #(.TIMEOUT_CYC(T), .HDR(HDR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not end, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    m_pos   = 0;
    m_quiet = 0;
    m_pend  = 1'b0;
    e_op    = 8'h00;
    e_addr  = 8'h00;
    e_wdata = 16'h0000;
    e_ferr  = 1'b0;
    e_code  = 2'b00;
    for (int i = 0; i < 6; i++) m_buf[i] = 8'h00;
  endfunction

  // One clock of the framing rules, given the inputs seen at that edge.
  function automatic void model_step(input bit d, input logic [7:0] b, input bit rdy);
    e_ferr = 1'b0;
    if (m_pend) begin
      if (d) begin
        e_ferr = 1'b1;
        e_code = 2'b11;
      end
      if (rdy) m_pend = 1'b0;
    end else if (m_pos == 0) begin
      if (d && b == HDR) begin
        m_pos   = 1;
        m_quiet = 0;
      end
    end else if (d) begin
      m_buf[m_pos] = b;
      m_quiet = 0;
      if (m_pos == 5) begin
        if ((m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4]) == b) begin
          m_pend  = 1'b1;
          e_op    = m_buf[1];
          e_addr  = m_buf[2];
          e_wdata = {m_buf[3], m_buf[4]};
        end else begin
          e_ferr = 1'b1;
          e_code = 2'b01;
        end
        m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end else if (m_quiet >= int'(T)) begin
      m_pos  = 0;
      e_ferr = 1'b1;
      e_code = 2'b10;
    end else begin
      m_quiet = m_quiet + 1;
    end
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, and leave
  // the outputs ready to be sampled 1 time unit after the edge.
  task automatic tick(input bit d, input logic [7:0] b, input bit rdy);
    rx_done   = d;
    rx_data   = d ? b : 8'h00;
    cmd_ready = rdy;
    @(posedge clk);
    model_step(d, b, rdy);
    #1;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b0;
  endtask

  task automatic send6(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    tick(1'b1, b0, 1'b0);
    tick(1'b1, b1, 1'b0);
    tick(1'b1, b2, 1'b0);
    tick(1'b1, b3, 1'b0);
    tick(1'b1, b4, 1'b0);
    tick(1'b1, b5, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.cmd_valid got %0b want 0", cmd_valid); end
    n_cmp++; if (cmd_op !== 8'h00) begin n_bad++; $display("[TB] FAIL reset.cmd_op got %h want 00", cmd_op); end
    n_cmp++; if (cmd_addr !== 8'h00) begin n_bad++; $display("[TB] FAIL reset.cmd_addr got %h want 00", cmd_addr); end
    n_cmp++; if (cmd_wdata !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset.cmd_wdata got %h want 0000", cmd_wdata); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset.frame_err got %0b want 0", frame_err); end
    n_cmp++; if (err_code !== 2'b00) begin n_bad++; $display("[TB] FAIL reset.err_code got %b want 00", err_code); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_valid_frame();
    // cmd_ready pulsed while nothing is offered must be ignored
    tick(1'b0, 8'h00, 1'b1);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_ready.cmd_valid got %0b want 0", cmd_valid); end
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h10, 1'b0);
    tick(1'b1, 8'h12, 1'b0);
    tick(1'b1, 8'h34, 1'b0);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL valid.early_valid got %0b want 0", cmd_valid); end
    tick(1'b1, 8'h37, 1'b0);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL valid.cmd_valid got %0b want 1", cmd_valid); end
    n_cmp++; if (cmd_op !== 8'h01) begin n_bad++; $display("[TB] FAIL valid.cmd_op got %h want 01", cmd_op); end
    n_cmp++; if (cmd_addr !== 8'h10) begin n_bad++; $display("[TB] FAIL valid.cmd_addr got %h want 10", cmd_addr); end
    n_cmp++; if (cmd_wdata !== 16'h1234) begin n_bad++; $display("[TB] FAIL valid.cmd_wdata got %h want 1234", cmd_wdata); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL valid.frame_err got %0b want 0", frame_err); end
    tick(1'b0, 8'h00, 1'b0);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL valid.hold got %0b want 1", cmd_valid); end
    tick(1'b0, 8'h00, 1'b1);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL valid.after_handshake got %0b want 0", cmd_valid); end
    n_cmp++; if (cmd_wdata !== 16'h1234) begin n_bad++; $display("[TB] FAIL valid.fields_kept got %h want 1234", cmd_wdata); end
  endtask

  task automatic test_bad_checksum();
    send6(8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h38);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL badchk.cmd_valid got %0b want 0", cmd_valid); end
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("[TB] FAIL badchk.frame_err got %0b want 1", frame_err); end
    n_cmp++; if (err_code !== 2'b01) begin n_bad++; $display("[TB] FAIL badchk.err_code got %b want 01", err_code); end
    tick(1'b0, 8'h00, 1'b0);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL badchk.pulse_width got %0b want 0", frame_err); end
    n_cmp++; if (err_code !== 2'b01) begin n_bad++; $display("[TB] FAIL badchk.code_sticky got %b want 01", err_code); end
  endtask

  task automatic test_noise_prefix();
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b1, 8'hFF, 1'b1);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL noise.frame_err got %0b want 0", frame_err); end
    send6(8'hA5, 8'h02, 8'h20, 8'h00, 8'h05, 8'h27);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL noise.cmd_valid got %0b want 1", cmd_valid); end
    n_cmp++; if (cmd_op !== 8'h02) begin n_bad++; $display("[TB] FAIL noise.cmd_op got %h want 02", cmd_op); end
    n_cmp++; if (cmd_addr !== 8'h20) begin n_bad++; $display("[TB] FAIL noise.cmd_addr got %h want 20", cmd_addr); end
    n_cmp++; if (cmd_wdata !== 16'h0005) begin n_bad++; $display("[TB] FAIL noise.cmd_wdata got %h want 0005", cmd_wdata); end
    tick(1'b0, 8'h00, 1'b1);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL noise.after_handshake got %0b want 0", cmd_valid); end
  endtask

  task automatic test_timeout();
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    for (int i = 1; i <= int'(T) + 10; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (frame_err === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        n_cmp++; if (err_code !== 2'b10) begin n_bad++; $display("[TB] FAIL timeout.err_code got %b want 10", err_code); end
      end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("[TB] FAIL timeout.pulses got %0d want 1", pulses); end
    n_cmp++; if (first < int'(T) || first > int'(T) + 1) begin n_bad++; $display("[TB] FAIL timeout.latency got %0d want %0d..%0d", first, T, T + 1); end
    send6(8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL timeout.recover_valid got %0b want 1", cmd_valid); end
    n_cmp++; if (cmd_wdata !== 16'h1234) begin n_bad++; $display("[TB] FAIL timeout.recover_wdata got %h want 1234", cmd_wdata); end
    tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_timeout_race();
    int errs;
    errs = 0;
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    repeat (T) begin
      tick(1'b0, 8'h00, 1'b0);
      if (frame_err === 1'b1) errs++;
    end
    tick(1'b1, 8'h10, 1'b0);
    if (frame_err === 1'b1) errs++;
    tick(1'b1, 8'h12, 1'b0);
    tick(1'b1, 8'h34, 1'b0);
    tick(1'b1, 8'h37, 1'b0);
    n_cmp++; if (errs != 0) begin n_bad++; $display("[TB] FAIL race.frame_err_count got %0d want 0", errs); end
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL race.cmd_valid got %0b want 1", cmd_valid); end
    n_cmp++; if (cmd_addr !== 8'h10) begin n_bad++; $display("[TB] FAIL race.cmd_addr got %h want 10", cmd_addr); end
    tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_overrun();
    // 04 ^ 22 ^ AB ^ CD = 40
    send6(8'hA5, 8'h04, 8'h22, 8'hAB, 8'hCD, 8'h40);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL overrun.hold_valid got %0b want 1", cmd_valid); end
    tick(1'b1, 8'h55, 1'b0);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("[TB] FAIL overrun.frame_err got %0b want 1", frame_err); end
    n_cmp++; if (err_code !== 2'b11) begin n_bad++; $display("[TB] FAIL overrun.err_code got %b want 11", err_code); end
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL overrun.cmd_valid got %0b want 1", cmd_valid); end
    n_cmp++; if ({cmd_op, cmd_addr, cmd_wdata} !== 32'h0422ABCD) begin n_bad++; $display("[TB] FAIL overrun.fields got %h want 0422abcd", {cmd_op, cmd_addr, cmd_wdata}); end
    tick(1'b0, 8'h00, 1'b0);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL overrun.pulse_width got %0b want 0", frame_err); end
    tick(1'b0, 8'h00, 1'b1);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL overrun.after_handshake got %0b want 0", cmd_valid); end
  endtask

  task automatic test_overrun_handshake();
    send6(8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
    tick(1'b1, 8'h66, 1'b1);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("[TB] FAIL ovr_hs.frame_err got %0b want 1", frame_err); end
    n_cmp++; if (err_code !== 2'b11) begin n_bad++; $display("[TB] FAIL ovr_hs.err_code got %b want 11", err_code); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ovr_hs.cmd_valid got %0b want 0", cmd_valid); end
    tick(1'b0, 8'h00, 1'b0);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL ovr_hs.pulse_width got %0b want 0", frame_err); end
  endtask

  task automatic test_reset_midframe();
    int errs;
    errs = 0;
    // Reset while a command is pending
    send6(8'hA5, 8'h04, 8'h22, 8'hAB, 8'hCD, 8'h40);
    rst_n = 1'b0;
    #2;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_hold.cmd_valid got %0b want 0", cmd_valid); end
    n_cmp++; if ({cmd_op, cmd_addr, cmd_wdata} !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_hold.fields got %h want 00000000", {cmd_op, cmd_addr, cmd_wdata}); end
    n_cmp++; if (err_code !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_hold.err_code got %b want 00", err_code); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // Reset part-way through a frame
    tick(1'b1, 8'hA5, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h10, 1'b0);
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({cmd_valid, frame_err, err_code} !== 4'b0000) begin n_bad++; $display("[TB] FAIL rst_mid.outputs got %b want 0000", {cmd_valid, frame_err, err_code}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) begin
      tick(1'b0, 8'h00, 1'b0);
      if (frame_err !== 1'b0 || cmd_valid !== 1'b0) errs++;
    end
    n_cmp++; if (errs != 0) begin n_bad++; $display("[TB] FAIL rst_mid.post_release got %0d bad cycles want 0", errs); end
    send6(8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'h02);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid.cmd_valid got %0b want 1", cmd_valid); end
    n_cmp++; if (cmd_op !== 8'h03) begin n_bad++; $display("[TB] FAIL rst_mid.cmd_op got %h want 03", cmd_op); end
    n_cmp++; if (cmd_wdata !== 16'h0001) begin n_bad++; $display("[TB] FAIL rst_mid.cmd_wdata got %h want 0001", cmd_wdata); end
    tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic [8:0] ev[$];
    logic [7:0] f [0:5];
    int gap;
    int njunk;
    for (int fr = 0; fr < 40; fr++) begin
      njunk = $urandom_range(0, 2);
      for (int j = 0; j < njunk; j++) ev.push_back({1'b1, 8'($urandom)});
      f[0] = HDR;
      for (int k = 1; k < 5; k++) f[k] = 8'($urandom);
      f[5] = f[1] ^ f[2] ^ f[3] ^ f[4];
      if ($urandom_range(0, 4) == 0) f[5] = f[5] ^ 8'($urandom_range(1, 255));
      for (int k = 0; k < 6; k++) begin
        gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(T - 5, T + 5)) : int'($urandom_range(0, 3));
        repeat (gap) ev.push_back(9'h000);
        ev.push_back({1'b1, f[k]});
      end
      repeat ($urandom_range(0, 6)) ev.push_back(9'h000);
    end
    foreach (ev[i]) begin
      tick(ev[i][8], ev[i][7:0], $urandom_range(0, 3) != 0);
      n_cmp++; if (cmd_valid !== m_pend) begin n_bad++; $display("[TB] FAIL rand[%0d].cmd_valid got %0b want %0b", i, cmd_valid, m_pend); end
      n_cmp++; if (frame_err !== e_ferr) begin n_bad++; $display("[TB] FAIL rand[%0d].frame_err got %0b want %0b", i, frame_err, e_ferr); end
      n_cmp++; if (err_code !== e_code) begin n_bad++; $display("[TB] FAIL rand[%0d].err_code got %b want %b", i, err_code, e_code); end
      n_cmp++; if ({cmd_op, cmd_addr, cmd_wdata} !== {e_op, e_addr, e_wdata}) begin n_bad++; $display("[TB] FAIL rand[%0d].fields got %h want %h", i, {cmd_op, cmd_addr, cmd_wdata}, {e_op, e_addr, e_wdata}); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_noise_prefix();
    test_timeout();
    test_timeout_race();
    test_overrun();
    test_overrun_handshake();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
